param_cache: RTL



---
 rtl/param_cache.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/param_cache.sv
// param_cache: blocking set-associative write-back cache between a CPU
// load/store port and an AXI bridge's line/word channels. Victims are chosen
// invalid-first, then by a per-set round-robin pointer. Uncached requests go
// straight to the bridge as single words and never touch the arrays.
module param_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4,
  localparam int INDEX_W   = $clog2(SETS),
  localparam int OFFSET_W  = $clog2(LINE_WORDS) + 2,
  localparam int TAG_W     = 32 - INDEX_W - OFFSET_W,
  localparam int LINE_BITS = 32 * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 op,
  input  logic                 uncached,
  input  logic [INDEX_W-1:0]   index,
  input  logic [TAG_W-1:0]     tag,
  input  logic [OFFSET_W-1:0]  offset,
  input  logic [3:0]           wstrb,
  input  logic [31:0]          wdata,
  output logic                 addr_ok,
  output logic                 data_ok,
  output logic [31:0]          rdata,
  output logic                 rd_req,
  output logic [2:0]           rd_type,
  output logic [31:0]          rd_addr,
  input  logic                 rd_rdy,
  input  logic                 ret_valid,
  input  logic                 ret_last,
  input  logic [31:0]          ret_data,
  output logic                 wr_req,
  output logic [2:0]           wr_type,
  output logic [31:0]          wr_addr,
  output logic [3:0]           wr_wstrb,
  output logic [LINE_BITS-1:0] wr_data,
  input  logic                 wr_rdy
);
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = OFFSET_W - 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REPLACE, REFILL, UC_RD, UC_WR} state_t;

  // Byte-lane merge of new write data over an existing word.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  // Storage: tag/data hold no reset value; valid, dirty and pointers do.
  logic [LINE_WORDS-1:0][31:0] r_data [WAYS][SETS];
  logic [TAG_W-1:0]            r_tags [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0]   r_vld, r_dirty;
  logic [SETS-1:0][PTR_W-1:0]  r_ptr;

  state_t             r_state;
  logic               r_op;
  logic [INDEX_W-1:0] r_idx;
  logic [TAG_W-1:0]   r_rtag;
  logic [CNT_W-1:0]   r_word;
  logic [3:0]         r_wstrb;
  logic [31:0]        r_wdata;
  logic [PTR_W-1:0]   r_victim;
  logic               r_used_inv;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_cap;
  logic               r_uc_sent;

  logic                        w_hit, w_inv_found;
  logic [PTR_W-1:0]            w_hit_way, w_victim;
  logic [LINE_WORDS-1:0][31:0] w_hit_line, w_vic_line;
  logic [31:0]                 w_hit_word, w_beat;
  logic [TAG_W-1:0]            w_vic_tag;
  logic                        w_vic_dirty, w_refill_fire, w_refill_last;
  logic                        w_unused;

  // Byte offset bits never matter: all accesses are whole words.
  assign w_unused = &{1'b0, offset[1:0]};

  // Tag compare across ways and victim choice (lowest invalid way wins).
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_victim    = r_ptr[r_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (r_vld[w][r_idx] && (r_tags[w][r_idx] == r_rtag)) begin
        w_hit     = 1'b1;
        w_hit_way = PTR_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_vld[w][r_idx]) begin
        w_inv_found = 1'b1;
        w_victim    = PTR_W'(w);
      end
    end
  end

  assign w_hit_line    = r_data[w_hit_way][r_idx];
  assign w_hit_word    = w_hit_line[r_word];
  assign w_vic_line    = r_data[r_victim][r_idx];
  assign w_vic_tag     = r_tags[r_victim][r_idx];
  assign w_vic_dirty   = r_vld[r_victim][r_idx] & r_dirty[r_victim][r_idx];
  assign w_refill_fire = (r_state == REFILL) & ret_valid;
  assign w_refill_last = w_refill_fire & ret_last;
  // A write miss folds its data into the matching beat on the way in.
  assign w_beat = (r_op && (r_cnt == r_word)) ? merge(ret_data, r_wdata, r_wstrb) : ret_data;

  // Tag and data array writes: write hits and refill beats.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == LOOKUP && w_hit && r_op)
        r_data[w_hit_way][r_idx][r_word] <= merge(w_hit_word, r_wdata, r_wstrb);
      if (w_refill_fire)
        r_data[r_victim][r_idx][r_cnt] <= w_beat;
      if (w_refill_last)
        r_tags[r_victim][r_idx] <= r_rtag;
    end
  end

  // Control FSM with request buffer, valid/dirty bits and replacement pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_vld      <= '0;
      r_dirty    <= '0;
      r_ptr      <= '0;
      r_op       <= 1'b0;
      r_idx      <= '0;
      r_rtag     <= '0;
      r_word     <= '0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_victim   <= '0;
      r_used_inv <= 1'b0;
      r_cnt      <= '0;
      r_cap      <= '0;
      r_uc_sent  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (valid) begin
          r_op      <= op;
          r_idx     <= index;
          r_rtag    <= tag;
          r_word    <= offset[OFFSET_W-1:2];
          r_wstrb   <= wstrb;
          r_wdata   <= wdata;
          r_uc_sent <= 1'b0;
          r_state   <= uncached ? (op ? UC_WR : UC_RD) : LOOKUP;
        end
        LOOKUP: if (w_hit) begin
          if (r_op) r_dirty[w_hit_way][r_idx] <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_victim   <= w_victim;
          r_used_inv <= w_inv_found;
          r_state    <= MISS;
        end
        MISS: if (!w_vic_dirty || wr_rdy) r_state <= REPLACE;
        REPLACE: if (rd_rdy) begin
          r_cnt   <= '0;
          r_state <= REFILL;
        end
        REFILL: if (ret_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == r_word) r_cap <= w_beat;
          if (ret_last) begin
            r_vld[r_victim][r_idx]   <= 1'b1;
            r_dirty[r_victim][r_idx] <= r_op;
            if (!r_used_inv) r_ptr[r_idx] <= (WAYS == 1) ? '0 : r_ptr[r_idx] + 1'b1;
            r_state <= IDLE;
          end
        end
        UC_RD: if (!r_uc_sent) begin
          if (rd_rdy) r_uc_sent <= 1'b1;
        end else if (ret_valid && ret_last) begin
          r_uc_sent <= 1'b0;
          r_state   <= IDLE;
        end
        UC_WR: if (wr_rdy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode; everything idles at zero and is forced low during reset.
  always_comb begin
    addr_ok  = (r_state == IDLE);
    data_ok  = 1'b0;
    rdata    = '0;
    rd_req   = 1'b0;
    rd_type  = '0;
    rd_addr  = '0;
    wr_req   = 1'b0;
    wr_type  = '0;
    wr_addr  = '0;
    wr_wstrb = '0;
    wr_data  = '0;
    case (r_state)
      LOOKUP: if (w_hit) begin
        data_ok = 1'b1;
        rdata   = w_hit_word;
      end
      MISS: if (w_vic_dirty) begin
        wr_req   = 1'b1;
        wr_type  = 3'b100;
        wr_addr  = {w_vic_tag, r_idx, {OFFSET_W{1'b0}}};
        wr_wstrb = 4'b1111;
        wr_data  = w_vic_line;
      end
      REPLACE: begin
        rd_req  = 1'b1;
        rd_type = 3'b100;
        rd_addr = {r_rtag, r_idx, {OFFSET_W{1'b0}}};
      end
      REFILL: if (ret_valid && ret_last) begin
        data_ok = 1'b1;
        rdata   = (r_cnt == r_word) ? w_beat : r_cap;
      end
      UC_RD: if (!r_uc_sent) begin
        rd_req  = 1'b1;
        rd_type = 3'b010;
        rd_addr = {r_rtag, r_idx, r_word, 2'b00};
      end else if (ret_valid && ret_last) begin
        data_ok = 1'b1;
        rdata   = ret_data;
      end
      UC_WR: begin
        wr_req   = 1'b1;
        wr_type  = 3'b010;
        wr_addr  = {r_rtag, r_idx, r_word, 2'b00};
        wr_wstrb = r_wstrb;
        wr_data  = LINE_BITS'(r_wdata);
        data_ok  = wr_rdy;
      end
      default: ;
    endcase
    if (reset) begin
      addr_ok  = 1'b0;
      data_ok  = 1'b0;
      rdata    = '0;
      rd_req   = 1'b0;
      rd_type  = '0;
      rd_addr  = '0;
      wr_req   = 1'b0;
      wr_type  = '0;
      wr_addr  = '0;
      wr_wstrb = '0;
      wr_data  = '0;
    end
  end
endmodule
